// File: rtl/grant_controller.sv
// grant_controller
//
// Sequential wrapper around an external 8-bit lowest-index-wins combinational
// arbiter. Single-cycle request pulses are latched into a pending register.
// That register drives the arbiter input, and the arbiter's one-hot pick is
// captured as a held grant. The grant stays frozen until the grantee signals
// done. There is no preemption.
//
// Optional feature: define GRANT_TIMEOUT_EN to force a release after TIMEOUT
// GRANT cycles without done. The release is flagged by a one-cycle timeout
// pulse. Without the macro, GRANT waits indefinitely and timeout is tied to 0.
//
// Parameters
//   TIMEOUT        max GRANT cycles without done (1..255), GRANT_TIMEOUT_EN only
// Ports
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   req_pulse[7:0] request pulses, each set bit latches into pending
//   arb_req[7:0]   pending register, drives the arbiter input
//   arb_grant[7:0] arbiter output, one-hot or zero
//   done           current grantee finished (ignored outside GRANT)
//   grant[7:0]     held one-hot grant, zero when not granting
//   grant_valid    high while in GRANT
//   grant_idx[2:0] binary index of grant, 0 when grant is zero
//   pending_count  popcount of arb_req (0..8)
//   timeout        one-cycle pulse on forced release
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no grant held; takes the arbiter pick when anything pends
// GRANT | grant frozen; waits for done (or forced release on timeout)

module grant_controller #(
    parameter int TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_pulse,
    output logic [7:0] arb_req,
    input  logic [7:0] arb_grant,
    input  logic       done,
    output logic [7:0] grant,
    output logic       grant_valid,
    output logic [2:0] grant_idx,
    output logic [3:0] pending_count,
    output logic       timeout
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("grant_controller: TIMEOUT must be in 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] grant_q, grant_d;
    logic [2:0] idx_q, idx_d;
    logic [3:0] count_q, count_d;
    logic       timeout_q, timeout_d;
    logic [7:0] clear;

`ifdef GRANT_TIMEOUT_EN
    // Counter holds (GRANT cycles elapsed - 1), so the forced release happens
    // at the edge closing the TIMEOUT-th GRANT cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
`ifdef GRANT_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
`ifdef GRANT_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        clear     = '0;
        timeout_d = 1'b0;
`ifdef GRANT_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif

        case (state_q)
            IDLE: begin
                // A zero arbiter result with requests pending is treated as
                // "nothing to grant" rather than entering GRANT with no owner.
                if (pending_q != '0 && arb_grant != '0) begin
                    grant_d = arb_grant;
                    state_d = GRANT;
`ifdef GRANT_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            GRANT: begin
                if (done) begin
                    clear   = grant_q;
                    grant_d = '0;
                    state_d = IDLE;
                end
`ifdef GRANT_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    clear     = grant_q;
                    grant_d   = '0;
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        // Set wins over clear so a re-request at release time is not lost.
        pending_d = (pending_q & ~clear) | req_pulse;

        count_d = '0;
        idx_d   = '0;
        for (int i = 0; i < 8; i++) begin
            count_d = count_d + 4'(pending_d[i]);
            if (grant_d[i]) begin
                idx_d = 3'(i);
            end
        end
    end

    assign arb_req       = pending_q;
    assign grant         = grant_q;
    assign grant_valid   = (state_q == GRANT);
    assign grant_idx     = idx_q;
    assign pending_count = count_q;
    assign timeout       = timeout_q;

endmodule

// File: doc/grant_controller.md
# grant_controller

Sequential wrapper around the 8-bit lowest-index-wins priority arbiter. It latches single-cycle request pulses into a pending register and drives that register as the arbiter's `in`. It captures the arbiter's one-hot `out` as a held grant and keeps that grant stable until the granted requester signals `done`. The block sits directly upstream and downstream of the combinational arbiter: it feeds it and consumes its result, turning a purely combinational pick into a granted, acknowledged transaction.

## Interface
- `TIMEOUT`, default 15: max GRANT cycles without `done` before forced release. Used only when `GRANT_TIMEOUT_EN` is defined. Legal range 1..255.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `req_pulse` input 8: request pulses; bit i high for ≥1 cycle sets pending bit i.
- `arb_req` output 8: pending register, wired to the arbiter `in`.
- `arb_grant` input 8: arbiter `out`; one-hot or zero, combinational from `arb_req`.
- `done` input 1: current grantee finished; ignored outside GRANT.
- `grant` output 8: held one-hot grant; zero when not granting.
- `grant_valid` output 1: high in GRANT state.
- `grant_idx` output 3: binary index of `grant`; 0 when `grant` = 0.
- `pending_count` output 4: popcount of `arb_req`, range 0..8.
- `timeout` output 1: one-cycle pulse on forced release.

## Operation
- Reset values: `arb_req`=0, `grant`=0, `grant_valid`=0, `grant_idx`=0, `pending_count`=0, `timeout`=0, state IDLE, timeout counter 0.
- Pending register update at each edge: `pending <= (pending & ~clear) | req_pulse`.
  - `clear` is the held grant when `done` is sampled in GRANT, or on timeout; otherwise 0.
  - Set wins: a `req_pulse` bit coinciding with its own clear leaves the bit pending.
- State IDLE:
  - If `arb_req` ≠ 0, register `grant <= arb_grant` and go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT:
  - `grant` is frozen. New requests, including higher-priority ones, only accumulate in `pending`; there is no preemption.
  - On `done`=1: clear the granted pending bit, set `grant <= 0`, go to IDLE.
- `grant_idx` and `pending_count` are registered and updated at the same edge as `grant` and `arb_req`.
- Defensive behaviour: if `arb_grant` = 0 while `arb_req` ≠ 0 in IDLE, stay in IDLE and raise no grant.

## Timing
- Request-to-grant latency:
  - `req_pulse[i]` sampled at edge t gives `arb_req[i]`=1 from t.
  - If in IDLE, `grant_valid`=1 from t+1.
- Release:
  - `done` sampled at edge t gives `grant_valid`=0 and the pending bit cleared from t.
  - The next grant is visible from t+1 at the earliest. The minimum gap between grants is one cycle with `grant_valid`=0.
- Back-to-back service: a grantee holding `done`=1 permanently is served every other cycle.
- Mid-operation reset (`rst_n` low at any time): all outputs are forced to reset values immediately and pending requests are lost. Operation resumes at the first edge after deassertion.
- `done` high in IDLE: no effect.

## Configuration
- `GRANT_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering GRANT and increments each GRANT cycle.
  - When the counter reaches `TIMEOUT` with `done`=0, treat it as a forced release: clear the pending bit, drop the grant, go to IDLE, and pulse `timeout` for one cycle.
  - If `done` and the timeout coincide, treat it as a normal `done` with `timeout`=0.
- `GRANT_TIMEOUT_EN` not defined: no counter; GRANT waits indefinitely for `done`; `timeout` is tied to 0.

## Test plan
- Reset, then a single pulse `req_pulse`=00100000 at t → `arb_req`=00100000 at t, `grant`=00100000, `grant_idx`=5, `grant_valid`=1 at t+1. Then `done` → `arb_req`=0, `grant_valid`=0.
- Pulse 00000110, serve with `done` each GRANT cycle → grants 00000010 then 00000100 with one idle cycle between. `pending_count` goes 2→1→0.
- While holding grant 00000100, pulse 00000001 → `grant` stays 00000100 until `done`. The next grant is 00000001.
- `done` coinciding with `req_pulse`=00000100 while bit 2 is granted → bit 2 remains pending and is re-granted next IDLE.
- Pulse 11111111, drop `rst_n` during GRANT → all outputs are 0 asynchronously. After release, no grant without new pulses.
- With `GRANT_TIMEOUT_EN`, `TIMEOUT`=4, grant 10000000 and `done` held low → `timeout` pulses once after 4 GRANT cycles, `grant`=0, `arb_req`=0.
